// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants and types for the instruction fetch slice.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int ADDR_W  = 32;
    localparam int INST_W  = 32;
    localparam int PC_STEP = 4;

    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DROP  = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/inst_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_if
// Description : Instruction memory req/ready bus between fetch and memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_fetch_if #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int INST_W = cpu_pkg::INST_W
);
    import cpu_pkg::*;

    logic              Imem_req;
    logic [ADDR_W-1:0] Imem_addr;
    logic              Imem_ready;
    logic [INST_W-1:0] Imem_rdata;

    modport master (
        output Imem_req,
        output Imem_addr,
        input  Imem_ready,
        input  Imem_rdata
    );

    modport slave (
        input  Imem_req,
        input  Imem_addr,
        output Imem_ready,
        output Imem_rdata
    );

endinterface : inst_fetch_if
`default_nettype wire

// File: rtl/ifid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : ifid_buffer
// Description : One-entry IF/ID register holding a fetched word and its PC.
// Revision    : 1.0 - initial release
// ============================================================================
module ifid_buffer #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int INST_W = cpu_pkg::INST_W
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_fill,
    input  wire logic [INST_W-1:0] i_fill_inst,
    input  wire logic [ADDR_W-1:0] i_fill_pc,
    input  wire logic              i_drain,
    input  wire logic              i_flush,
    output logic                   o_valid,
    output logic      [INST_W-1:0] o_inst,
    output logic      [ADDR_W-1:0] o_pc
);
    import cpu_pkg::*;

    logic              valid_q, valid_d;
    logic [INST_W-1:0] inst_q,  inst_d;
    logic [ADDR_W-1:0] pc_q,    pc_d;

    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        if (i_fill) begin
            valid_d = 1'b1;
            inst_d  = i_fill_inst;
            pc_d    = i_fill_pc;
        end else if (i_drain) begin
            valid_d = 1'b0;
        end
        // A flush beats a same-cycle fill so wrong-path words never surface.
        if (i_flush) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= ADDR_W'(RESET_PC);
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
        end
    end

    assign o_valid = valid_q;
    assign o_inst  = inst_q;
    assign o_pc    = pc_q;

endmodule : ifid_buffer
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : Fetch stage: imem handshake, IF/ID buffer and next-PC select.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch #(
    parameter int ADDR_W  = cpu_pkg::ADDR_W,
    parameter int INST_W  = cpu_pkg::INST_W,
    parameter int PC_STEP = cpu_pkg::PC_STEP
) (
    input  wire logic              Clock,
    input  wire logic              Reset,
    input  wire logic [ADDR_W-1:0] Pc_reg,
    output logic      [ADDR_W-1:0] Address_out,
    input  wire logic              Redirect_valid,
    input  wire logic [ADDR_W-1:0] Redirect_addr,
    inst_fetch_if.master           imem,
    output logic                   Inst_valid,
    output logic      [INST_W-1:0] Inst_out,
    output logic      [ADDR_W-1:0] Inst_pc,
    input  wire logic              Decode_ready,
    output logic                   Inst_fault
);
    import cpu_pkg::*;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] drop_addr_q, drop_addr_d;

    logic              w_space;
    logic              w_misaligned;
    logic              w_req;
    logic [ADDR_W-1:0] w_addr;
    logic              w_done;
    logic              w_fill;
    logic              w_drain;

    always_comb begin
        w_space      = !Inst_valid || Decode_ready;
        w_misaligned = (Pc_reg[1:0] != 2'b00);
        w_req        = 1'b0;
        w_addr       = Pc_reg;
        state_d      = state_q;
        drop_addr_d  = drop_addr_q;

        case (state_q)
            FETCH: begin
                w_req = w_space && !w_misaligned;
                if (Redirect_valid) begin
                    // A request already on the bus must be seen through to ready.
                    if (w_req && !imem.Imem_ready) begin
                        state_d     = DROP;
                        drop_addr_d = Pc_reg;
                    end
                end else if (w_misaligned) begin
                    state_d = FAULT;
                end
            end
            DROP: begin
                w_req  = 1'b1;
                w_addr = drop_addr_q;
                if (imem.Imem_ready) begin
                    state_d = FETCH;
                end
            end
            FAULT: begin
                if (Redirect_valid) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        if (Reset) begin
            w_req = 1'b0;
        end

        w_done  = (state_q == FETCH) && w_req && imem.Imem_ready;
        w_fill  = w_done && !Redirect_valid;
        w_drain = Inst_valid && Decode_ready;

        if (Reset) begin
            Address_out = '0;
        end else if (Redirect_valid) begin
            Address_out = Redirect_addr;
        end else if (w_done) begin
            Address_out = Pc_reg + ADDR_W'(PC_STEP);
        end else begin
            Address_out = Pc_reg;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= FETCH;
            drop_addr_q <= ADDR_W'(RESET_PC);
        end else begin
            state_q     <= state_d;
            drop_addr_q <= drop_addr_d;
        end
    end

    ifid_buffer #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_ifid_buffer (
        .clk         (Clock),
        .rst         (Reset),
        .i_fill      (w_fill),
        .i_fill_inst (imem.Imem_rdata),
        .i_fill_pc   (Pc_reg),
        .i_drain     (w_drain),
        .i_flush     (Redirect_valid),
        .o_valid     (Inst_valid),
        .o_inst      (Inst_out),
        .o_pc        (Inst_pc)
    );

    assign imem.Imem_req  = w_req;
    assign imem.Imem_addr = w_addr;
    assign Inst_fault     = (state_q == FAULT);

endmodule : inst_fetch
`default_nettype wire

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction fetch stage directly downstream of the PC register.
- Takes the current `Pc_reg` and fetches the instruction word from instruction memory over a req/ready handshake.
- Holds the fetched word in a one-entry IF/ID buffer until decode accepts it.
- Computes the next-PC value fed back to the PC register's `Address_in`. The PC register loads every clock, so this block holds the PC by driving back the current value.

Parameters:
- ADDR_W, 32, PC / memory address width
- INST_W, 32, instruction word width
- PC_STEP, 4, byte increment per sequential fetch

Ports:
- `Clock`  in  1  system clock, rising edge
- `Reset`  in  1  synchronous, active-high reset
- `Pc_reg`  in  ADDR_W  current PC from PC register
- `Address_out`  out  ADDR_W  next PC, to PC register `Address_in`
- `Redirect_valid`  in  1  branch/jump taken this cycle
- `Redirect_addr`  in  ADDR_W  redirect target
- `Imem_req`  out  1  instruction memory request
- `Imem_addr`  out  ADDR_W  request address
- `Imem_ready`  in  1  memory returns data this cycle
- `Imem_rdata`  in  INST_W  instruction data, valid with `Imem_ready`
- `Inst_valid`  out  1  IF/ID buffer holds a valid instruction
- `Inst_out`  out  INST_W  buffered instruction
- `Inst_pc`  out  ADDR_W  PC of buffered instruction
- `Decode_ready`  in  1  decode accepts buffer this cycle
- `Inst_fault`  out  1  misaligned PC detected (sticky until redirect/reset)

Behaviour:
- FSM states: FETCH, DROP, FAULT. One-entry buffer (`buf_valid`, `buf_inst`, `buf_pc`) kept separately.
- Reset (sampled on rising `Clock` while `Reset`=1):
  - state=FETCH; `buf_valid`=0; `Inst_fault`=0; `Inst_out`=0; `Inst_pc`=0.
  - `Imem_req`=0 and `Address_out`=0 while `Reset` is high.
- Buffer accept condition `space` = !`buf_valid` || `Decode_ready`. Drain happens when `buf_valid` && `Decode_ready`.
- FETCH:
  - `Imem_req`=`space` && `Pc_reg[1:0]`==0.
  - `Imem_addr`=`Pc_reg`, combinational.
  - Once `Imem_req` is asserted it stays high with a stable address until `Imem_ready`. `space` cannot drop while waiting, since the buffer only empties.
- Fetch completes when `Imem_req` && `Imem_ready`:
  - next cycle: `buf_valid`=1, `buf_inst`=`Imem_rdata`, `buf_pc`=`Pc_reg`.
  - if no drain-only event, `buf_valid` reflects the new word (fill and drain in the same cycle are both allowed).
  - Latency: `Imem_ready` at cycle N gives `Inst_valid` at N+1.
- `Address_out` priority, combinational:
  - `Reset` → 0
  - else `Redirect_valid` → `Redirect_addr`
  - else fetch completes this cycle → `Pc_reg`+PC_STEP, truncated mod 2^ADDR_W so 0xFFFFFFFC wraps to 0
  - else → `Pc_reg` (hold)
- Redirect:
  - clears `buf_valid` next cycle, overriding any simultaneous fill.
  - clears `Inst_fault`.
  - If `Imem_req` is high and `Imem_ready` is low in the redirect cycle, go to DROP. An outstanding request is never withdrawn.
  - If `Imem_ready` is high in the redirect cycle, the returned data is discarded and the state stays FETCH.
- DROP:
  - `Imem_req` stays high, `Imem_addr` = latched old address.
  - on `Imem_ready`, discard data and go to FETCH.
  - `Address_out` = `Pc_reg` (already the redirect target); a further redirect in DROP updates the PC only.
- Misalignment: in FETCH with `Pc_reg[1:0]`!=0, no request is issued. Next cycle: FAULT with `Inst_fault`=1, and `Address_out` holds. FAULT exits only on redirect or reset.
- Decode stall: `Decode_ready`=0 with a full buffer gives no new request and the PC held.
- Reset mid-request: the request is abandoned. The memory side must tolerate it (reset is system-wide).

Decomposition:
- Shared package `cpu_pkg`: ADDR_W, INST_W, PC_STEP constants; FSM state enum `fetch_state_t` {FETCH, DROP, FAULT}; RESET_PC = 0.
- One natural sub-module: `ifid_buffer`, the one-entry valid/data/pc register with fill/drain/flush inputs. FSM and next-PC mux stay in `inst_fetch`.

Test Plan:
- Reset then zero-wait memory (`Imem_ready`=`Imem_req`), `Decode_ready`=1 → `Address_out` sequence 4, 8, 12; `Inst_pc` 0, 4, 8 one cycle behind; one instruction per cycle.
- Memory returns with 3-cycle wait at PC 0x10 → `Imem_req` held 3 cycles with `Imem_addr`=0x10; `Address_out`=0x10 until the ready cycle, then 0x14.
- `Decode_ready`=0 for 4 cycles with buffer full → `Imem_req`=0, `Inst_out` stable, PC held. Release → drain and new fill in the same cycle.
- Redirect to 0x100 while request to 0x20 is pending → DROP; 0x20 data discarded, `Inst_valid`=0, next fetch at 0x100, first `Inst_pc`=0x100.
- Redirect to 0x102 → `Inst_fault`=1 next cycle, no `Imem_req`. Redirect to 0x200 → fault cleared, fetch at 0x200.
- Reset asserted mid-wait at PC 0x40 → next cycle `Imem_req`=0, `Inst_valid`=0, `Address_out`=0. After release, fetch at 0.
